systolic_sequencer: RTL and testbench

Control FSM that runs a program of up to 8 instructions against the 4x4 systolic array. Each instruction is a 4-bit inner dimension N; value 0 halts. For each instruction the block fetches from instruction memory, clears the array accumulators and streams N columns from input memories A/B. It then drains the array pipeline, pulses the output-memory write, and advances. Sits between the top-level ap_start/ap_done handshake and the memories/array.

---
 rtl/systolic_sequencer.sv | 159 +++++++++++++++
 tb/tb_systolic_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_sequencer.sv
// systolic_sequencer: program sequencer for the 4x4 systolic array.
// Walks up to NUM_INST instructions (inner dimension N, 0 = halt). For each
// instruction it fetches the instruction, clears the array accumulators,
// streams N columns from input memories A/B, waits for the skewed array
// pipeline to drain, then pulses the output-memory write.
module systolic_sequencer #(
  parameter int unsigned DRAIN_CYCLES = 7,
  parameter int unsigned NUM_INST     = 8,
  parameter int unsigned COL_W        = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        ap_start,
  output logic                        ap_done,
  output logic                        ap_idle,
  output logic                        inst_rd_en,
  output logic [$clog2(NUM_INST)-1:0] inst_addr,
  input  logic [3:0]                  inst_data,
  output logic                        sa_clear,
  output logic                        rd_en_a,
  output logic                        rd_en_b,
  output logic [COL_W-1:0]            rd_col,
  output logic                        out_wen,
  output logic [3:0]                  inst_count
);

  localparam int unsigned AW    = $clog2(NUM_INST);
  // cnt serves both the stream index (up to 15) and the drain countdown
  localparam int unsigned CNT_W = (DRAIN_CYCLES > 16) ? $clog2(DRAIN_CYCLES) : 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_WRITE,
    S_DONE
  } state_t;

  state_t           state;
  logic [COL_W-1:0] col_base;
  logic [3:0]       len;
  logic [CNT_W-1:0] cnt;

  logic             last_col;
  logic             last_drain;
  logic             last_inst;

  // terminal-count decodes used by the state register
  always_comb begin
    last_col   = (cnt == CNT_W'(len - 4'd1));
    last_drain = (cnt == CNT_W'(DRAIN_CYCLES - 1));
    last_inst  = (inst_addr == AW'(NUM_INST - 1));
  end

  // sequencer state and all registered (Moore) outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      ap_done    <= 1'b0;
      ap_idle    <= 1'b1;
      inst_rd_en <= 1'b0;
      inst_addr  <= '0;
      sa_clear   <= 1'b0;
      rd_en_a    <= 1'b0;
      rd_en_b    <= 1'b0;
      rd_col     <= '0;
      out_wen    <= 1'b0;
      inst_count <= '0;
      col_base   <= '0;
      len        <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (ap_start) begin
            state      <= S_FETCH;
            ap_done    <= 1'b0;
            ap_idle    <= 1'b0;
            inst_rd_en <= 1'b1;
            inst_addr  <= '0;
            col_base   <= '0;
            inst_count <= '0;
          end
        end

        S_FETCH: begin
          inst_rd_en <= 1'b0;
          state      <= S_DECODE;
        end

        S_DECODE: begin
          len <= inst_data;
          if (inst_data == 4'd0) begin
            state   <= S_DONE;
            ap_done <= 1'b1;
            ap_idle <= 1'b1;
          end else begin
            state    <= S_CLEAR;
            sa_clear <= 1'b1;
          end
        end

        S_CLEAR: begin
          sa_clear <= 1'b0;
          cnt      <= '0;
          rd_en_a  <= 1'b1;
          rd_en_b  <= 1'b1;
          rd_col   <= col_base;
          state    <= S_STREAM;
        end

        // rd_col tracks col_base+cnt by incrementing alongside cnt
        S_STREAM: begin
          if (last_col) begin
            rd_en_a <= 1'b0;
            rd_en_b <= 1'b0;
            rd_col  <= '0;
            cnt     <= '0;
            state   <= S_DRAIN;
          end else begin
            cnt    <= cnt + CNT_W'(1);
            rd_col <= rd_col + COL_W'(1);
          end
        end

        S_DRAIN: begin
          if (last_drain) begin
            cnt     <= '0;
            out_wen <= 1'b1;
            state   <= S_WRITE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        S_WRITE: begin
          out_wen    <= 1'b0;
          col_base   <= col_base + COL_W'(len);
          inst_count <= inst_count + 4'd1;
          if (last_inst) begin
            state   <= S_DONE;
            ap_done <= 1'b1;
            ap_idle <= 1'b1;
          end else begin
            inst_addr  <= inst_addr + AW'(1);
            inst_rd_en <= 1'b1;
            state      <= S_FETCH;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed bench for systolic_sequencer. A second instance with a 5-bit
// column index runs the same programs so column wrap-around is reachable.
module tb_systolic_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ap_start = 1'b0;

  logic       ap_done, ap_idle, inst_rd_en, sa_clear, rd_en_a, rd_en_b, out_wen;
  logic [2:0] inst_addr;
  logic [3:0] inst_data = '0;
  logic [7:0] rd_col;
  logic [3:0] inst_count;

  logic       ap_done2, ap_idle2, inst_rd_en2, sa_clear2, rd_en_a2, rd_en_b2, out_wen2;
  logic [2:0] inst_addr2;
  logic [3:0] inst_data2 = '0;
  logic [4:0] rd_col2;
  logic [3:0] inst_count2;

  logic [3:0] prog [8];

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int s;

  systolic_sequencer #(.DRAIN_CYCLES(7), .NUM_INST(8), .COL_W(8)) dut (
    .clk(clk), .rst(rst), .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle),
    .inst_rd_en(inst_rd_en), .inst_addr(inst_addr), .inst_data(inst_data),
    .sa_clear(sa_clear), .rd_en_a(rd_en_a), .rd_en_b(rd_en_b), .rd_col(rd_col),
    .out_wen(out_wen), .inst_count(inst_count)
  );

  systolic_sequencer #(.DRAIN_CYCLES(7), .NUM_INST(8), .COL_W(5)) dut2 (
    .clk(clk), .rst(rst), .ap_start(ap_start), .ap_done(ap_done2), .ap_idle(ap_idle2),
    .inst_rd_en(inst_rd_en2), .inst_addr(inst_addr2), .inst_data(inst_data2),
    .sa_clear(sa_clear2), .rd_en_a(rd_en_a2), .rd_en_b(rd_en_b2), .rd_col(rd_col2),
    .out_wen(out_wen2), .inst_count(inst_count2)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // instruction memories: one-cycle read latency
  always @(posedge clk) if (inst_rd_en)  inst_data  <= prog[inst_addr];
  always @(posedge clk) if (inst_rd_en2) inst_data2 <= prog[inst_addr2];

  // event log sampled on the falling edge
  int   fetch_t[$], fetch_a[$], clr_t[$], col_t[$], col_v[$], wen_t[$], done_t[$], col2_v[$];
  int   wen2_n = 0, clr2_n = 0, enb_bad = 0;
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (inst_rd_en) begin fetch_t.push_back(cyc); fetch_a.push_back(int'(inst_addr)); end
    if (sa_clear) clr_t.push_back(cyc);
    if (rd_en_a) begin col_t.push_back(cyc); col_v.push_back(int'(rd_col)); end
    if (out_wen) wen_t.push_back(cyc);
    if (rd_en_a2) col2_v.push_back(int'(rd_col2));
    if (out_wen2) wen2_n++;
    if (sa_clear2) clr2_n++;
    if (rd_en_b !== rd_en_a || rd_en_b2 !== rd_en_a2) enb_bad++;
    if (ap_done && !prev_done) done_t.push_back(cyc);
    prev_done = ap_done;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    fetch_t.delete(); fetch_a.delete(); clr_t.delete(); col_t.delete(); col_v.delete();
    wen_t.delete(); done_t.delete(); col2_v.delete();
    wen2_n = 0; clr2_n = 0;
  endtask

  // leaves the bench on the sample where cyc == s and the DUT is in FETCH
  task automatic start_pulse();
    tick();
    clear_log();
    ap_start = 1'b1;
    s = cyc + 1;
    tick();
    ap_start = 1'b0;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (ap_done) begin ok = 1'b1; break; end
    end
    tick();
  endtask

  task automatic test_reset();
    bit seen;
    repeat (3) tick();
    n_vec++; if (ap_idle !== 1'b1) begin n_err++; $display("FAIL rst_idle: got %b want 1", ap_idle); end
    n_vec++; if (ap_done !== 1'b0) begin n_err++; $display("FAIL rst_done: got %b want 0", ap_done); end
    n_vec++; if ({inst_rd_en, sa_clear, rd_en_a, rd_en_b, out_wen} !== 5'b0) begin
      n_err++; $display("FAIL rst_enables: got %b want 00000", {inst_rd_en, sa_clear, rd_en_a, rd_en_b, out_wen}); end
    n_vec++; if ({inst_addr, rd_col, inst_count} !== 15'd0) begin
      n_err++; $display("FAIL rst_values: addr %0d col %0d count %0d want 0", inst_addr, rd_col, inst_count); end
    rst = 1'b1;
    repeat (2) tick();
    n_vec++; if (ap_idle !== 1'b1) begin n_err++; $display("FAIL idle_after_rst: got %b want 1", ap_idle); end

    // abort in the middle of a stream
    prog = '{4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    start_pulse();
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rd_en_a) begin seen = 1'b1; break; end
      tick();
    end
    n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL mid_rst_reach_stream: got %b want 1", seen); end
    repeat (3) tick();
    rst = 1'b0;
    #1;
    n_vec++; if ({rd_en_a, rd_en_b, sa_clear, out_wen, inst_rd_en} !== 5'b0) begin
      n_err++; $display("FAIL mid_rst_enables: got %b want 00000", {rd_en_a, rd_en_b, sa_clear, out_wen, inst_rd_en}); end
    n_vec++; if (ap_idle !== 1'b1 || inst_count !== 4'd0 || rd_col !== 8'd0) begin
      n_err++; $display("FAIL mid_rst_state: idle %b count %0d col %0d want 1 0 0", ap_idle, inst_count, rd_col); end
    clear_log();
    tick();
    rst = 1'b1;
    repeat (30) tick();
    n_vec++; if (wen_t.size() != 0) begin n_err++; $display("FAIL mid_rst_no_write: got %0d writes want 0", wen_t.size()); end
    n_vec++; if (ap_idle !== 1'b1 || ap_done !== 1'b0) begin
      n_err++; $display("FAIL mid_rst_stays_idle: idle %b done %b want 1 0", ap_idle, ap_done); end
  endtask

  task automatic test_single();
    bit ok;
    prog = '{4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    start_pulse();
    n_vec++; if (inst_rd_en !== 1'b1 || inst_addr !== 3'd0) begin
      n_err++; $display("FAIL single_fetch0: rd_en %b addr %0d want 1 0", inst_rd_en, inst_addr); end
    wait_done(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL single_timeout: got no ap_done want ap_done"); end
    n_vec++; if (fetch_t.size() != 2 || fetch_t[1] != s + 15 || fetch_a[1] != 1) begin
      n_err++; $display("FAIL single_fetch1: n %0d t %0d addr %0d want 2 %0d 1", fetch_t.size(), fetch_t[1] - s, fetch_a[1], 15); end
    n_vec++; if (clr_t.size() != 1 || clr_t[0] != s + 2) begin
      n_err++; $display("FAIL single_clear: n %0d t %0d want 1 2", clr_t.size(), clr_t[0] - s); end
    n_vec++; if (col_v.size() != 4 || col_v[0] != 0 || col_v[3] != 3 || col_t[0] != s + 3 || col_t[3] != s + 6) begin
      n_err++; $display("FAIL single_stream: n %0d first %0d@%0d last %0d@%0d want 4 0@3 3@6",
                        col_v.size(), col_v[0], col_t[0] - s, col_v[3], col_t[3] - s); end
    n_vec++; if (wen_t.size() != 1 || wen_t[0] != s + 14) begin
      n_err++; $display("FAIL single_wen: n %0d t %0d want 1 14", wen_t.size(), wen_t[0] - s); end
    n_vec++; if (done_t.size() != 1 || done_t[0] != s + 17) begin
      n_err++; $display("FAIL single_done_time: n %0d t %0d want 1 17", done_t.size(), done_t[0] - s); end
    n_vec++; if (inst_count !== 4'd1 || ap_idle !== 1'b1) begin
      n_err++; $display("FAIL single_count: count %0d idle %b want 1 1", inst_count, ap_idle); end
  endtask

  task automatic test_two();
    bit ok;
    prog = '{4'd2, 4'd3, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    start_pulse();
    wait_done(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL two_timeout: got no ap_done want ap_done"); end
    n_vec++; if (col_v.size() != 5 || col_v[0] != 0 || col_v[1] != 1 || col_v[2] != 2 || col_v[4] != 4) begin
      n_err++; $display("FAIL two_cols: n %0d %0d %0d %0d %0d want 5 0 1 2 4", col_v.size(), col_v[0], col_v[1], col_v[2], col_v[4]); end
    n_vec++; if (clr_t.size() != 2 || clr_t[0] != s + 2 || clr_t[1] != s + 15 || col_t[2] != s + 16) begin
      n_err++; $display("FAIL two_clear: n %0d t %0d %0d stream2 %0d want 2 2 15 16", clr_t.size(), clr_t[0] - s, clr_t[1] - s, col_t[2] - s); end
    n_vec++; if (wen_t.size() != 2 || wen_t[0] != s + 12 || wen_t[1] != s + 26) begin
      n_err++; $display("FAIL two_wen: n %0d t %0d %0d want 2 12 26", wen_t.size(), wen_t[0] - s, wen_t[1] - s); end
    n_vec++; if (done_t.size() != 1 || done_t[0] != s + 29 || inst_count !== 4'd2) begin
      n_err++; $display("FAIL two_done: t %0d count %0d want 29 2", done_t[0] - s, inst_count); end
  endtask

  task automatic test_halt0();
    bit ok;
    prog = '{4'd0, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5, 4'd5};
    start_pulse();
    wait_done(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL halt_timeout: got no ap_done want ap_done"); end
    n_vec++; if (done_t.size() != 1 || done_t[0] != s + 2) begin
      n_err++; $display("FAIL halt_done_time: n %0d t %0d want 1 2", done_t.size(), done_t[0] - s); end
    n_vec++; if (clr_t.size() != 0 || col_v.size() != 0 || wen_t.size() != 0 || fetch_t.size() != 1) begin
      n_err++; $display("FAIL halt_pulses: clr %0d rd %0d wen %0d fetch %0d want 0 0 0 1",
                        clr_t.size(), col_v.size(), wen_t.size(), fetch_t.size()); end
    n_vec++; if (inst_count !== 4'd0) begin n_err++; $display("FAIL halt_count: got %0d want 0", inst_count); end
  endtask

  task automatic test_full_and_rerun();
    bit ok;
    int bad;
    prog = '{4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15, 4'd15};
    start_pulse();
    wait_done(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL full_timeout: got no ap_done want ap_done"); end
    bad = 0;
    for (int i = 0; i < col_v.size(); i++) if (col_v[i] != i) bad++;
    n_vec++; if (col_v.size() != 120 || bad != 0 || col_v[119] != 119) begin
      n_err++; $display("FAIL full_cols: n %0d wrong %0d last %0d want 120 0 119", col_v.size(), bad, col_v[119]); end
    n_vec++; if (wen_t.size() != 8 || fetch_t.size() != 8 || fetch_a[7] != 7) begin
      n_err++; $display("FAIL full_counts: wen %0d fetch %0d lastaddr %0d want 8 8 7", wen_t.size(), fetch_t.size(), fetch_a[7]); end
    n_vec++; if (done_t.size() != 1 || done_t[0] != s + 208 || inst_count !== 4'd8) begin
      n_err++; $display("FAIL full_done: t %0d count %0d want 208 8", done_t[0] - s, inst_count); end

    // restart straight from DONE
    start_pulse();
    n_vec++; if (ap_done !== 1'b0 || inst_addr !== 3'd0 || inst_count !== 4'd0 || inst_rd_en !== 1'b1) begin
      n_err++; $display("FAIL rerun_start: done %b addr %0d count %0d rd_en %b want 0 0 0 1", ap_done, inst_addr, inst_count, inst_rd_en); end
    wait_done(ok);
    n_vec++; if (!ok || col_v.size() != 120 || col_v[0] != 0 || inst_count !== 4'd8) begin
      n_err++; $display("FAIL rerun_result: ok %b n %0d first %0d count %0d want 1 120 0 8", ok, col_v.size(), col_v[0], inst_count); end
  endtask

  task automatic test_ignore_start();
    bit ok;
    prog = '{4'd4, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    start_pulse();
    while (cyc < s + 4) tick();
    ap_start = 1'b1; tick(); ap_start = 1'b0;
    while (cyc < s + 9) tick();
    ap_start = 1'b1; tick(); ap_start = 1'b0;
    wait_done(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL ignore_timeout: got no ap_done want ap_done"); end
    n_vec++; if (fetch_t.size() != 2 || fetch_t[1] != s + 15 || col_v.size() != 4 || wen_t.size() != 1 || wen_t[0] != s + 14) begin
      n_err++; $display("FAIL ignore_timing: fetch %0d@%0d rd %0d wen %0d@%0d want 2@15 4 1@14",
                        fetch_t.size(), fetch_t[1] - s, col_v.size(), wen_t.size(), wen_t[0] - s); end
    n_vec++; if (done_t.size() != 1 || done_t[0] != s + 17 || inst_count !== 4'd1) begin
      n_err++; $display("FAIL ignore_done: t %0d count %0d want 17 1", done_t[0] - s, inst_count); end
  endtask

  task automatic test_wrap();
    bit ok;
    int bad;
    prog = '{4'd15, 4'd15, 4'd10, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    start_pulse();
    wait_done(ok);
    n_vec++; if (!ok) begin n_err++; $display("FAIL wrap_timeout: got no ap_done want ap_done"); end
    bad = 0;
    for (int i = 0; i < col_v.size(); i++) if (col_v[i] != i) bad++;
    n_vec++; if (col_v.size() != 40 || bad != 0 || done_t[0] != s + 75) begin
      n_err++; $display("FAIL wrap_wide_cols: n %0d wrong %0d done %0d want 40 0 75", col_v.size(), bad, done_t[0] - s); end
    bad = 0;
    for (int i = 0; i < col2_v.size(); i++) if (col2_v[i] != (i % 32)) bad++;
    n_vec++; if (col2_v.size() != 40 || bad != 0) begin
      n_err++; $display("FAIL wrap_narrow_cols: n %0d wrong %0d want 40 0", col2_v.size(), bad); end
    n_vec++; if (col2_v[30] != 30 || col2_v[31] != 31 || col2_v[32] != 0 || col2_v[39] != 7) begin
      n_err++; $display("FAIL wrap_point: %0d %0d %0d %0d want 30 31 0 7", col2_v[30], col2_v[31], col2_v[32], col2_v[39]); end
    n_vec++; if (ap_done2 !== 1'b1 || ap_idle2 !== 1'b1 || inst_count2 !== 4'd3 || wen2_n != 3 || clr2_n != 3) begin
      n_err++; $display("FAIL wrap_narrow_ctl: done %b idle %b count %0d wen %0d clr %0d want 1 1 3 3 3",
                        ap_done2, ap_idle2, inst_count2, wen2_n, clr2_n); end
    n_vec++; if (enb_bad != 0) begin n_err++; $display("FAIL rd_en_b_tracks_a: got %0d differing samples want 0", enb_bad); end
  endtask

  initial begin
    prog = '{default: 4'd0};
    test_reset();
    test_single();
    test_two();
    test_halt0();
    test_full_and_rerun();
    test_ignore_start();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
